dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 16-bit data words stored (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT, default 2, meaning the wait cycles inserted between request accept and response (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion and active-low.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  word address.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port req_ready  output  1  the responder can accept a request this cycle.
REQ-010 SHALL have port rsp_valid  output  1  the response is present.
REQ-011 SHALL have port rsp_rdata  output  16  read data; 16'h0000 for write responses.
REQ-012 SHALL have port rsp_ready  input  1  the initiator accepts the response.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE.
- Acceptance = req_valid & req_ready at a rising edge.
- On acceptance: latch req_we, req_addr and req_wdata.
REQ-015 SHALL transition on acceptance as follows:
- WAIT=0: IDLE->RESP.
- Otherwise: IDLE->BUSY, and load the wait counter with WAIT-1.
REQ-016 SHALL, in BUSY, decrement the counter each cycle and transition to RESP when the counter is 0.
- Result: rsp_valid rises exactly WAIT+1 cycles after the accepting edge.
REQ-017 SHALL, for a read, register the array word at index = latched addr modulo DEPTH into rsp_rdata on the RESP entry edge.
REQ-018 SHALL, for a write, update the array on the RESP entry edge and set rsp_rdata=0.
REQ-019 SHALL hold rsp_valid=1 and rsp_rdata stable in RESP until rsp_valid & rsp_ready at an edge; then RESP->IDLE.
REQ-020 SHALL ignore req_* inputs outside IDLE; no queueing; at most one outstanding request.
REQ-021 SHALL ensure a read following a write to the same address returns the newly written data.
REQ-022 SHALL, when rsp_ready is held high, allow back-to-back requests: the next accept is possible on the edge after the response handshake.
- Throughput: one request per WAIT+2 cycles.
REQ-023 SHALL derive rsp_valid and req_ready from registered state only, with no combinational path from any input.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, counter=0, req_ready=1 (after release), rsp_valid=0 and rsp_rdata=16'h0000.
REQ-025 SHALL abandon any in-flight request on reset mid-operation.
- A pending write not yet committed SHALL be dropped.
REQ-026 SHALL NOT reset the storage array contents.
- Contents after power-up are undefined.

Configuration
REQ-027 SHALL, with macro DMEM_RESPONDER_ERR_EN defined:
- Add output port rsp_err (1 bit, reset 0), valid with rsp_valid.
- Set rsp_err=1 when the latched req_addr >= DEPTH.
- For such a request, block the write, return rsp_rdata=16'hDEAD, and keep timing unchanged.
REQ-028 SHALL, with DMEM_RESPONDER_ERR_EN undefined:
- Omit port rsp_err.
- Wrap out-of-range addresses modulo DEPTH with no error indication.

Verification
REQ-029 SHALL verify reset mid-BUSY: with WAIT=2, write 16'h1234 to addr 5, then assert rst_n=0 the cycle after accept -> rsp_valid=0, req_ready=1 after release, and a read of addr 5 does not return 16'h1234 unless previously written.
REQ-030 SHALL verify write/read latency: with WAIT=2, write 16'hBEEF to addr 16'h0010, then read addr 16'h0010 -> rsp_valid rises exactly 3 cycles after each accept; read returns 16'hBEEF; write response rdata=0.
REQ-031 SHALL verify zero-wait operation: with WAIT=0 and rsp_ready held 1, issue 4 back-to-back reads -> each rsp_valid 1 cycle after accept; one response every 2 cycles.
REQ-032 SHALL verify response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, req_valid pulses ignored.
REQ-033 SHALL verify address wrap: DEPTH=256, write 16'h00AA to addr 16'h0103, read addr 16'h0003 -> returns 16'h00AA (macro undefined).
REQ-034 SHALL verify the error path: with DMEM_RESPONDER_ERR_EN defined and DEPTH=256, write 16'h5555 to addr 16'h0100 -> rsp_err=1; a subsequent read of addr 16'h0000 -> rsp_err=0 and data unchanged.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between an initiator (master)
// and dmem_responder (slave). Defining DMEM_RESPONDER_ERR_EN adds rsp_err.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_ready;
`ifdef DMEM_RESPONDER_ERR_EN
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: DEPTH x 16-bit word memory behind a valid/ready
// request/response handshake with a fixed WAIT-cycle access latency.
// One request outstanding at a time; the array is never reset.
// Optional macro DMEM_RESPONDER_ERR_EN: addresses >= DEPTH raise rsp_err,
// return 16'hDEAD and never write; otherwise addresses wrap modulo DEPTH.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// BUSY  | request latched, wait counter running down to 0
// RESP  | response presented, held until rsp_ready
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam bit         ZERO_WAIT = (WAIT == 0);
  localparam logic [2:0] WAIT_LOAD = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
`ifdef DMEM_RESPONDER_ERR_EN
  logic        err_q, err_d;
  logic        c_err;
`endif

  logic [15:0] mem_q [DEPTH];

  logic             accept;
  logic             commit;
  logic             mem_we;
  logic             c_we;
  logic [15:0]      c_addr;
  logic [15:0]      c_wdata;
  logic [IDX_W-1:0] c_idx;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
`ifdef DMEM_RESPONDER_ERR_EN
  assign bus.rsp_err   = err_q;
`endif

  assign accept = bus.req_valid & (state_q == IDLE);

  // Next-state logic: accept/latch in IDLE, count down in BUSY, handshake in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (ZERO_WAIT) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit operands: a zero-wait accept commits on the same edge, so it uses the live inputs
  always_comb begin
    if (state_q == IDLE) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
    c_idx = IDX_W'(32'(c_addr) % DEPTH);
  end

  // Response data and array write enable on the RESP entry edge
  always_comb begin
    rdata_d = rdata_q;
    mem_we  = 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
    err_d   = err_q;
    c_err   = (32'(c_addr) >= DEPTH);
`endif
    if (commit) begin
`ifdef DMEM_RESPONDER_ERR_EN
      err_d = c_err;
      if (c_err) rdata_d = 16'hDEAD;
      else
`endif
      if (c_we) begin
        rdata_d = 16'h0000;
        // a zero-wait accept can look valid while reset is held; never commit then
        mem_we  = rst_n;
      end else begin
        rdata_d = mem_q[c_idx];
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
`ifdef DMEM_RESPONDER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef DMEM_RESPONDER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage array: deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[c_idx] <= c_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (WAIT=2 and WAIT=0, DEPTH=256) driven by
// directed transactions; a transaction-level timeline model predicts
// req_ready / rsp_valid / rsp_rdata and is compared every falling edge.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W0    = 2;
  localparam int W1    = 0;
  localparam int WAITS [2] = '{W0, W1};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT(W0)) u_w2 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dmem_responder #(.DEPTH(DEPTH), .WAIT(W1)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic        in_v  [2];
  logic        in_we [2];
  logic [15:0] in_a  [2];
  logic [15:0] in_d  [2];
  logic        in_rr [2];

  assign bus0.req_valid = in_v[0];
  assign bus0.req_we    = in_we[0];
  assign bus0.req_addr  = in_a[0];
  assign bus0.req_wdata = in_d[0];
  assign bus0.rsp_ready = in_rr[0];
  assign bus1.req_valid = in_v[1];
  assign bus1.req_we    = in_we[1];
  assign bus1.req_addr  = in_a[1];
  assign bus1.req_wdata = in_d[1];
  assign bus1.rsp_ready = in_rr[1];

  logic        ob_rr [2];
  logic        ob_rv [2];
  logic [15:0] ob_rd [2];
  logic        ob_er [2];
  assign ob_rr[0] = bus0.req_ready;
  assign ob_rv[0] = bus0.rsp_valid;
  assign ob_rd[0] = bus0.rsp_rdata;
  assign ob_rr[1] = bus1.req_ready;
  assign ob_rv[1] = bus1.rsp_valid;
  assign ob_rd[1] = bus1.rsp_rdata;
`ifdef DMEM_RESPONDER_ERR_EN
  assign ob_er[0] = bus0.rsp_err;
  assign ob_er[1] = bus1.rsp_err;
`else
  assign ob_er[0] = 1'b0;
  assign ob_er[1] = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A request accepted on edge A makes rsp_valid visible from edge A+WAIT on,
  // the array is committed on that edge, and the response leaves on the first
  // later edge with rsp_ready=1. Requests are only taken with nothing outstanding.
  int          cyc = 0;
  bit          m_out   [2];
  int          m_acc   [2];
  bit          m_we    [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wd    [2];
  logic [15:0] m_rd    [2];
  bit          m_known [2];
  bit          m_err   [2];
  logic [15:0] m_mem   [2][DEPTH];
  bit          m_wr    [2][DEPTH];
  bit          mv_was;
  int          mv_idx;
  bit          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k]   = 1'b0;
        m_rd[k]    = 16'h0000;
        m_known[k] = 1'b1;
        m_err[k]   = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        mv_was = m_out[k];
        if (mv_was && (cyc - 1 - m_acc[k]) >= WAITS[k] && in_rr[k]) m_out[k] = 1'b0;
        if (!mv_was && in_v[k]) begin
          m_out[k]  = 1'b1;
          m_acc[k]  = cyc;
          m_we[k]   = in_we[k];
          m_addr[k] = in_a[k];
          m_wd[k]   = in_d[k];
        end
        if (m_out[k] && (cyc - m_acc[k]) == WAITS[k]) begin
          mv_idx   = int'(m_addr[k]) % DEPTH;
          m_err[k] = 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
          if (int'(m_addr[k]) >= DEPTH) begin
            m_err[k]   = 1'b1;
            m_rd[k]    = 16'hDEAD;
            m_known[k] = 1'b1;
          end else
`endif
          if (m_we[k]) begin
            m_mem[k][mv_idx] = m_wd[k];
            m_wr[k][mv_idx]  = 1'b1;
            m_rd[k]          = 16'h0000;
            m_known[k]       = 1'b1;
          end else begin
            m_rd[k]    = m_mem[k][mv_idx];
            m_known[k] = m_wr[k][mv_idx];
          end
        end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), 16'(ob_rr[k]), 16'(!m_out[k]));
        chk($sformatf("rsp_valid[%0d]", k), 16'(ob_rv[k]),
            16'(m_out[k] && (cyc - m_acc[k]) >= WAITS[k]));
        if (m_known[k]) chk($sformatf("rsp_rdata[%0d]", k), ob_rd[k], m_rd[k]);
`ifdef DMEM_RESPONDER_ERR_EN
        chk($sformatf("rsp_err[%0d]", k), 16'(ob_er[k]), 16'(m_err[k]));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic present(input int k, input bit we, input logic [15:0] a, input logic [15:0] d);
    bit ok;
    bit rdy;
    ok = 1'b0;
    in_we[k] = we;
    in_a[k]  = a;
    in_d[k]  = d;
    in_v[k]  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      rdy = ob_rr[k];
      @(posedge clk);
      #2;
      if (rdy) ok = 1'b1;
    end
    in_v[k] = 1'b0;
    chk("accept_in_time", 16'(ok), 16'd1);
  endtask

  // lat=1 means rsp_valid is seen in the cycle right after the accepting edge; 0 = never
  task automatic wait_rsp(input int k, output int lat, output logic [15:0] rd, output logic er);
    lat = 0;
    rd  = 16'hxxxx;
    er  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ob_rv[k]) begin
        lat = i;
        rd  = ob_rd[k];
        er  = ob_er[k];
        break;
      end
    end
  endtask

  task automatic do_req(input int k, input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er);
    present(k, we, a, d);
    wait_rsp(k, lat, rd, er);
    @(posedge clk);
    #2;
  endtask

  int          lat;
  logic [15:0] rd;
  logic        er;
  int          seen_q[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_v[k] = 1'b0; in_we[k] = 1'b0; in_a[k] = 16'h0; in_d[k] = 16'h0; in_rr[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rsp_valid", 16'(ob_rv[0]), 16'd0);
    chk("rst_rsp_rdata", ob_rd[0], 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready0", 16'(ob_rr[0]), 16'd1);
    chk("rst_req_ready1", 16'(ob_rr[1]), 16'd1);

    // reset in the middle of BUSY drops the pending write
    present(0, 1'b1, 16'h0005, 16'h1234);
    @(posedge clk);
    #2;
    chk("busy_req_ready", 16'(ob_rr[0]), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 16'(ob_rv[0]), 16'd0);
    chk("midrst_req_ready", 16'(ob_rr[0]), 16'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 16'(ob_rr[0]), 16'd1);
    @(posedge clk);
    #2;
    do_req(0, 1'b0, 16'h0005, 16'h0000, lat, rd, er);
    chk("dropped_write_lat", 16'(lat), 16'd3);
    chk("dropped_write_not_seen", 16'(rd != 16'h1234), 16'd1);

    // write then read, WAIT=2
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
    chk("wr_lat", 16'(lat), 16'd3);
    chk("wr_rdata_zero", rd, 16'h0000);
    do_req(0, 1'b0, 16'h0010, 16'h0000, lat, rd, er);
    chk("rd_lat", 16'(lat), 16'd3);
    chk("rd_beef", rd, 16'hBEEF);

`ifdef DMEM_RESPONDER_ERR_EN
    do_req(0, 1'b1, 16'h0000, 16'h0C0C, lat, rd, er);
    chk("err_pre_wr_err", 16'(er), 16'd0);
    do_req(0, 1'b1, 16'h0100, 16'h5555, lat, rd, er);
    chk("err_oor_flag", 16'(er), 16'd1);
    chk("err_oor_rdata", rd, 16'hDEAD);
    chk("err_oor_lat", 16'(lat), 16'd3);
    do_req(0, 1'b0, 16'h0000, 16'h0000, lat, rd, er);
    chk("err_rd0_flag", 16'(er), 16'd0);
    chk("err_rd0_data", rd, 16'h0C0C);
`else
    do_req(0, 1'b1, 16'h0103, 16'h00AA, lat, rd, er);
    do_req(0, 1'b0, 16'h0003, 16'h0000, lat, rd, er);
    chk("wrap_rdata", rd, 16'h00AA);
`endif

    // backpressure: rsp_ready low for 5 cycles, req_valid pulses ignored
    in_rr[0] = 1'b0;
    present(0, 1'b0, 16'h0010, 16'h0000);
    wait_rsp(0, lat, rd, er);
    chk("bp_lat", 16'(lat), 16'd3);
    chk("bp_first_rdata", rd, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      in_v[0]  = ((i % 2) == 0);
      in_we[0] = 1'b1;
      in_a[0]  = 16'h0010;
      in_d[0]  = 16'h9999;
      @(negedge clk);
      chk("bp_rsp_valid", 16'(ob_rv[0]), 16'd1);
      chk("bp_rsp_rdata", ob_rd[0], 16'hBEEF);
      chk("bp_req_ready", 16'(ob_rr[0]), 16'd0);
    end
    @(posedge clk);
    #2;
    in_v[0]  = 1'b0;
    in_rr[0] = 1'b1;
    @(posedge clk);
    #2;
    do_req(0, 1'b0, 16'h0010, 16'h0000, lat, rd, er);
    chk("bp_pulses_ignored", rd, 16'hBEEF);

    // zero-wait: single write, then four back-to-back reads
    do_req(1, 1'b1, 16'h0007, 16'h7777, lat, rd, er);
    chk("zw_wr_lat", 16'(lat), 16'd1);
    chk("zw_wr_rdata", rd, 16'h0000);
    in_we[1] = 1'b0;
    in_a[1]  = 16'h0007;
    in_v[1]  = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (ob_rv[1]) begin
        seen_q.push_back(i);
        chk("zw_b2b_rdata", ob_rd[1], 16'h7777);
      end
      if (i == 8) in_v[1] = 1'b0;
    end
    chk("zw_b2b_count", 16'(seen_q.size()), 16'd4);
    if (seen_q.size() == 4) begin
      chk("zw_first_rsp", 16'(seen_q[0]), 16'd2);
      for (int j = 1; j < 4; j++) chk("zw_rsp_spacing", 16'(seen_q[j] - seen_q[j-1]), 16'd2);
    end
    @(posedge clk);
    #2;

    // address/data sweep on both instances
    for (int i = 0; i < 6; i++)
      do_req(0, 1'b1, 16'(i * 41 + 9), 16'(16'hA000 + i * 17), lat, rd, er);
    for (int i = 0; i < 6; i++) begin
      do_req(0, 1'b0, 16'(i * 41 + 9), 16'h0000, lat, rd, er);
      chk("sweep_w2_rdata", rd, 16'(16'hA000 + i * 17));
    end
    for (int i = 0; i < 3; i++)
      do_req(1, 1'b1, 16'(i * 77 + 20), 16'(16'h3C00 + i * 5), lat, rd, er);
    for (int i = 0; i < 3; i++) begin
      do_req(1, 1'b0, 16'(i * 77 + 20), 16'h0000, lat, rd, er);
      chk("sweep_w0_rdata", rd, 16'(16'h3C00 + i * 5));
      chk("sweep_w0_lat", 16'(lat), 16'd1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
